// File: rtl/matrix_row_scanner.sv
// Row-multiplexed LED matrix scanner: double-buffered frame (pending/display)
// swapped only at the row-counter loop boundary, with one blank cycle per row change.
module matrix_row_scanner #(
    parameter int COLS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        row_idx,
    input  logic              loop_start,
    input  logic              frame_valid,
    input  logic [8*COLS-1:0] frame_data,
    output logic              frame_ready,
    output logic [7:0]        row_drv,
    output logic [COLS-1:0]   col_drv,
    output logic              frame_swap,
    output logic [7:0]        frames_shown,
    output logic              sync_err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [8*COLS-1:0]   pending_q;
    logic [8*COLS-1:0]   display_q, display_d;
    logic [7:0]          row_drv_q, row_drv_d;
    logic [COLS-1:0]     col_drv_q, col_drv_d;
    logic                frame_swap_q;
    logic [7:0]          frames_shown_q;
    logic                sync_err_q;
    logic                loop_start_q;
    logic [2:0]          row_q;

    logic                boundary;
    logic                accept;
    logic                swap;

    // Loop boundary is the rising edge of the active-low end-of-loop marker.
    assign boundary = !loop_start_q && loop_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (frame_valid) state_d = FULL;
            FULL:    if (boundary)    state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        frame_ready = (state_q == EMPTY);
        accept      = (state_q == EMPTY) && frame_valid;
        swap        = (state_q == FULL) && boundary;
    end

    // Rows are read from the post-swap display so the new frame shows immediately.
    always_comb begin
        display_d = swap ? pending_q : display_q;
        if (row_idx != row_q) begin
            row_drv_d = 8'hFF;
            col_drv_d = '0;
        end else begin
            row_drv_d = ~(8'b1 << row_idx);
            col_drv_d = display_d[int'(row_idx)*COLS +: COLS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            display_q      <= '0;
            row_drv_q      <= 8'hFF;
            col_drv_q      <= '0;
            frame_swap_q   <= 1'b0;
            frames_shown_q <= 8'd0;
            sync_err_q     <= 1'b0;
            loop_start_q   <= 1'b1;
            row_q          <= 3'd0;
        end else begin
            if (accept) pending_q <= frame_data;
            display_q      <= display_d;
            row_drv_q      <= row_drv_d;
            col_drv_q      <= col_drv_d;
            frame_swap_q   <= swap;
            frames_shown_q <= frames_shown_q + {7'd0, swap};
            sync_err_q     <= sync_err_q || (!loop_start && row_idx != 3'd7);
            loop_start_q   <= loop_start;
            row_q          <= row_idx;
        end
    end

    assign row_drv      = row_drv_q;
    assign col_drv      = col_drv_q;
    assign frame_swap   = frame_swap_q;
    assign frames_shown = frames_shown_q;
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner: frame swap timing, blanking, back-pressure,
// async reset, sticky sync error and frame counter wrap.
module tb_matrix_row_scanner;
    localparam int COLS = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        row_idx;
    logic              loop_start;
    logic              frame_valid;
    logic [8*COLS-1:0] frame_data;
    logic              frame_ready;
    logic [7:0]        row_drv;
    logic [COLS-1:0]   col_drv;
    logic              frame_swap;
    logic [7:0]        frames_shown;
    logic              sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    int swaps;
    logic [8*COLS-1:0] f1, f2, f3;

    matrix_row_scanner #(.COLS(COLS)) dut (
        .clk(clk), .reset(reset), .row_idx(row_idx), .loop_start(loop_start),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
        .row_drv(row_drv), .col_drv(col_drv), .frame_swap(frame_swap),
        .frames_shown(frames_shown), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_row(input logic [2:0] r, input logic ls);
        row_idx    = r;
        loop_start = ls;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        f1 = '0; f2 = '0; f3 = '0;
        f1[0*COLS +: COLS] = 5'b10101;
        f1[1*COLS +: COLS] = 5'b00001;
        f1[2*COLS +: COLS] = 5'b00011;
        f1[3*COLS +: COLS] = 5'b01110;
        f2[0*COLS +: COLS] = 5'b11000;
        f3[0*COLS +: COLS] = 5'b00110;
        f3[3*COLS +: COLS] = 5'b10001;

        reset = 1'b1; frame_valid = 1'b0; frame_data = '0;
        set_row(3'd0, 1'b1);
        #12;
        chk("rst_ready", frame_ready, 1);
        chk("rst_row",   row_drv, 8'hFF);
        chk("rst_col",   col_drv, 0);
        chk("rst_swap",  frame_swap, 0);
        chk("rst_shown", frames_shown, 0);
        chk("rst_err",   sync_err, 0);
        @(negedge clk) reset = 1'b0;

        // Load F1 while at row 7, then cross the loop boundary.
        set_row(3'd7, 1'b0);
        frame_valid = 1'b1; frame_data = f1;
        tick();
        chk("acc_ready", frame_ready, 0);
        frame_valid = 1'b0;
        tick();
        set_row(3'd0, 1'b1);
        tick();
        chk("sw1_pulse", frame_swap, 1);
        chk("sw1_shown", frames_shown, 1);
        chk("sw1_blank", row_drv, 8'hFF);
        chk("sw1_bcol",  col_drv, 0);
        tick();
        chk("sw1_off",   frame_swap, 0);
        chk("r0_drv",    row_drv, 8'hFE);
        chk("r0_col",    col_drv, 5'b10101);

        // Row change 2 -> 3: exactly one blank cycle.
        set_row(3'd2, 1'b1);
        tick(4);
        chk("r2_drv", row_drv, 8'hFB);
        chk("r2_col", col_drv, 5'b00011);
        set_row(3'd3, 1'b1);
        tick();
        chk("r3_blank", row_drv, 8'hFF);
        chk("r3_bcol",  col_drv, 0);
        tick();
        chk("r3_drv", row_drv, 8'hF7);
        chk("r3_col", col_drv, 5'b01110);
        tick(2);

        // Boundary while EMPTY: no swap, display retained.
        set_row(3'd7, 1'b0);
        tick(2);
        set_row(3'd0, 1'b1);
        tick();
        chk("nosw_pulse", frame_swap, 0);
        chk("nosw_shown", frames_shown, 1);
        tick();
        chk("nosw_col", col_drv, 5'b10101);

        // Back-pressure: F2 pending, F3 held until the slot frees.
        frame_valid = 1'b1; frame_data = f2;
        tick();
        chk("f2_ready", frame_ready, 0);
        frame_data = f3;
        tick(2);
        chk("f3_wait", frame_ready, 0);
        set_row(3'd7, 1'b0);
        tick(2);
        set_row(3'd0, 1'b1);
        tick();
        chk("sw2_pulse", frame_swap, 1);
        chk("sw2_shown", frames_shown, 2);
        chk("sw2_ready", frame_ready, 1);
        tick();
        chk("f3_acc",  frame_ready, 0);
        chk("f2_col",  col_drv, 5'b11000);
        frame_valid = 1'b0;
        set_row(3'd7, 1'b0);
        tick(2);
        chk("f2_still", frames_shown, 2);
        set_row(3'd0, 1'b1);
        tick();
        chk("sw3_shown", frames_shown, 3);
        tick();
        chk("f3_col", col_drv, 5'b00110);

        // Async reset while FULL with row 3 displayed.
        set_row(3'd3, 1'b1);
        tick(2);
        chk("pre_col", col_drv, 5'b10001);
        frame_valid = 1'b1; frame_data = f1;
        tick();
        chk("pre_full", frame_ready, 0);
        frame_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_row",   row_drv, 8'hFF);
        chk("arst_col",   col_drv, 0);
        chk("arst_ready", frame_ready, 1);
        chk("arst_shown", frames_shown, 0);
        @(negedge clk) reset = 1'b0;

        // Sticky sync error.
        set_row(3'd3, 1'b0);
        tick();
        chk("serr_set", sync_err, 1);
        for (int r = 0; r < 8; r++) begin
            set_row(r[2:0], (r != 7));
            tick(2);
        end
        set_row(3'd0, 1'b1);
        tick(2);
        chk("serr_hold", sync_err, 1);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("serr_clr", sync_err, 0);
        @(negedge clk) reset = 1'b0;

        // 256 swaps: frames_shown wraps to 0.
        swaps = 0;
        frame_valid = 1'b1; frame_data = f1;
        for (int i = 0; i < 256; i++) begin
            set_row(3'd7, 1'b0);
            tick();
            if (frame_swap) swaps++;
            set_row(3'd0, 1'b1);
            tick();
            if (frame_swap) swaps++;
            if (i == 254) chk("wrap_255", frames_shown, 255);
        end
        frame_valid = 1'b0;
        chk("wrap_pulses", swaps, 256);
        chk("wrap_zero",   frames_shown, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
